control_ajuste_hora: RTL and testbench

CONTROL_AJUSTE_HORA -- requirements
Module: control_ajuste_hora

---
 rtl/control_ajuste_hora.sv | 185 ++++++++++++++++++
 tb/tb_control_ajuste_hora.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/control_ajuste_hora.sv
// Time-setting controller: turns button edges and the 1 Hz tick into one-cycle
// enables for the hour/minute/second registers, with edit-mode field selection.
module control_ajuste_hora (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       btn_edit,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic       en_h,
   output logic       en_m,
   output logic       en_s,
   output logic       up,
   output logic       down,
   output logic [1:0] field_sel,
   output logic       editing,
   output logic       blink
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      EDIT_H = 2'd1,
      EDIT_M = 2'd2,
      EDIT_S = 2'd3
   } state_t;

   state_t     state_r, state_s;
   logic [5:0] sec_cnt_r, sec_cnt_s;
   logic [5:0] min_cnt_r, min_cnt_s;
   logic       edit_prev_r, left_prev_r, right_prev_r, up_prev_r, down_prev_r;
   logic       edit_edge_s, left_edge_s, right_edge_s, up_edge_s, down_edge_s;
   logic       en_h_s, en_m_s, en_s_s, up_s, down_s, blink_s;

   function automatic logic [5:0] inc60(input logic [5:0] v);
      inc60 = (v == 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [5:0] dec60(input logic [5:0] v);
      dec60 = (v == 6'd0) ? 6'd59 : v - 6'd1;
   endfunction

   function automatic state_t next_field(input state_t s);
      case (s)
         EDIT_H:  next_field = EDIT_M;
         EDIT_M:  next_field = EDIT_S;
         EDIT_S:  next_field = EDIT_H;
         default: next_field = RUN;
      endcase
   endfunction

   function automatic state_t prev_field(input state_t s);
      case (s)
         EDIT_H:  prev_field = EDIT_S;
         EDIT_M:  prev_field = EDIT_H;
         EDIT_S:  prev_field = EDIT_M;
         default: prev_field = RUN;
      endcase
   endfunction

   function automatic logic [1:0] sel_of(input state_t s);
      case (s)
         EDIT_H:  sel_of = 2'b00;
         EDIT_M:  sel_of = 2'b01;
         EDIT_S:  sel_of = 2'b10;
         default: sel_of = 2'b11;
      endcase
   endfunction

   assign edit_edge_s  = btn_edit  & ~edit_prev_r;
   assign left_edge_s  = btn_left  & ~left_prev_r;
   assign right_edge_s = btn_right & ~right_prev_r;
   assign up_edge_s    = btn_up    & ~up_prev_r;
   assign down_edge_s  = btn_down  & ~down_prev_r;

   // Next state, counter and output decode; edit edge outranks left/right, which outrank up/down.
   always_comb begin
      state_s   = state_r;
      sec_cnt_s = sec_cnt_r;
      min_cnt_s = min_cnt_r;
      blink_s   = blink;
      en_h_s    = 1'b0;
      en_m_s    = 1'b0;
      en_s_s    = 1'b0;
      up_s      = 1'b0;
      down_s    = 1'b0;
      if (edit_edge_s) begin
         state_s = (state_r == RUN) ? EDIT_H : RUN;
         blink_s = 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               blink_s = 1'b0;
               if (tick_1hz) begin
                  en_s_s    = 1'b1;
                  up_s      = 1'b1;
                  sec_cnt_s = inc60(sec_cnt_r);
                  if (sec_cnt_r == 6'd59) begin
                     en_m_s    = 1'b1;
                     min_cnt_s = inc60(min_cnt_r);
                     en_h_s    = (min_cnt_r == 6'd59);
                  end else begin
                     en_m_s = 1'b0;
                  end
               end else begin
                  en_s_s = 1'b0;
               end
            end
            default: begin
               blink_s = tick_1hz ? ~blink : blink;
               if (left_edge_s || right_edge_s) begin
                  // simultaneous left+right is ignored but still swallows up/down
                  if (left_edge_s && !right_edge_s) begin
                     state_s = prev_field(state_r);
                     blink_s = 1'b0;
                  end else if (right_edge_s && !left_edge_s) begin
                     state_s = next_field(state_r);
                     blink_s = 1'b0;
                  end else begin
                     state_s = state_r;
                  end
               end else if (up_edge_s ^ down_edge_s) begin
                  up_s   = up_edge_s;
                  down_s = down_edge_s;
                  case (state_r)
                     EDIT_H: en_h_s = 1'b1;
                     EDIT_M: begin
                        en_m_s    = 1'b1;
                        min_cnt_s = up_edge_s ? inc60(min_cnt_r) : dec60(min_cnt_r);
                     end
                     EDIT_S: begin
                        en_s_s    = 1'b1;
                        sec_cnt_s = up_edge_s ? inc60(sec_cnt_r) : dec60(sec_cnt_r);
                     end
                     default: en_h_s = 1'b0;
                  endcase
               end else begin
                  up_s = 1'b0;
               end
            end
         endcase
      end
   end

   // State, shadow counters, button history and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= RUN;
         sec_cnt_r    <= 6'd0;
         min_cnt_r    <= 6'd0;
         edit_prev_r  <= btn_edit;
         left_prev_r  <= btn_left;
         right_prev_r <= btn_right;
         up_prev_r    <= btn_up;
         down_prev_r  <= btn_down;
         en_h         <= 1'b0;
         en_m         <= 1'b0;
         en_s         <= 1'b0;
         up           <= 1'b0;
         down         <= 1'b0;
         blink        <= 1'b0;
         editing      <= 1'b0;
         field_sel    <= 2'b11;
      end else begin
         state_r      <= state_s;
         sec_cnt_r    <= sec_cnt_s;
         min_cnt_r    <= min_cnt_s;
         edit_prev_r  <= btn_edit;
         left_prev_r  <= btn_left;
         right_prev_r <= btn_right;
         up_prev_r    <= btn_up;
         down_prev_r  <= btn_down;
         en_h         <= en_h_s;
         en_m         <= en_m_s;
         en_s         <= en_s_s;
         up           <= up_s;
         down         <= down_s;
         blink        <= blink_s;
         editing      <= (state_s != RUN);
         field_sel    <= sel_of(state_s);
      end
   end

endmodule

// File: tb/tb_control_ajuste_hora.sv
// Scoreboard bench for control_ajuste_hora: stimulus pushes expected enable
// pulses with their due cycle; a monitor pops and compares each pulse seen.
module tb_control_ajuste_hora;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       btn_edit = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0;
   logic       en_h, en_m, en_s, up, down, editing, blink;
   logic [1:0] field_sel;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   typedef struct {
      logic [4:0] v;
      int         c;
   } exp_t;
   exp_t q[$];

   // bit order {tick, edit, left, right, up, down}
   localparam logic [5:0] M_TICK  = 6'b100000;
   localparam logic [5:0] M_EDIT  = 6'b010000;
   localparam logic [5:0] M_LEFT  = 6'b001000;
   localparam logic [5:0] M_RIGHT = 6'b000100;
   localparam logic [5:0] M_UP    = 6'b000010;
   localparam logic [5:0] M_DOWN  = 6'b000001;

   // pulse vectors {en_h, en_m, en_s, up, down}
   localparam logic [4:0] V_S_UP   = 5'b00110;
   localparam logic [4:0] V_SM_UP  = 5'b01110;
   localparam logic [4:0] V_HMS_UP = 5'b11110;
   localparam logic [4:0] V_M_DN   = 5'b01001;
   localparam logic [4:0] V_S_DN   = 5'b00101;
   localparam logic [4:0] V_H_UP   = 5'b10010;

   control_ajuste_hora dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
      .btn_edit(btn_edit), .btn_left(btn_left), .btn_right(btn_right),
      .btn_up(btn_up), .btn_down(btn_down),
      .en_h(en_h), .en_m(en_m), .en_s(en_s), .up(up), .down(down),
      .field_sel(field_sel), .editing(editing), .blink(blink)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every enable pulse must match the head of the scoreboard, on its due cycle.
   always @(posedge clk) begin
      #1;
      if (en_h || en_m || en_s) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pulse cyc=%0d got=%b want=none", cyc, {en_h, en_m, en_s, up, down});
         end else begin
            exp_t e;
            e = q.pop_front();
            if ({en_h, en_m, en_s, up, down} !== e.v || cyc != e.c) begin
               n_err++;
               $display("FAIL pulse got=%b@%0d want=%b@%0d", {en_h, en_m, en_s, up, down}, cyc, e.v, e.c);
            end
         end
      end else if (up || down) begin
         n_cmp++;
         n_err++;
         $display("FAIL idle_dir cyc=%0d up=%b down=%b want 0 0", cyc, up, down);
      end
   end

   task automatic press(input logic [5:0] m, input bit has_exp, input logic [4:0] ev);
      exp_t e;
      @(negedge clk);
      {tick_1hz, btn_edit, btn_left, btn_right, btn_up, btn_down} = m;
      if (has_exp) begin
         e.v = ev;
         e.c = cyc + 1;
         q.push_back(e);
      end
      @(negedge clk);
      {tick_1hz, btn_edit, btn_left, btn_right, btn_up, btn_down} = 6'b000000;
   endtask

   task automatic chk_st(input string name, input logic [3:0] exp_st);
      n_cmp++;
      if ({field_sel, editing, blink} !== exp_st) begin
         n_err++;
         $display("FAIL %s got sel/edit/blink=%b want=%b", name, {field_sel, editing, blink}, exp_st);
      end
   endtask

   task automatic drain(input string name);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL %s pending=%0d want=0", name, q.size());
         q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({en_h, en_m, en_s, up, down, blink, editing, field_sel} !== 9'b000000011) begin
         n_err++;
         $display("FAIL reset_vals got=%b want=000000011", {en_h, en_m, en_s, up, down, blink, editing, field_sel});
      end
      rst = 1'b1;
      @(negedge clk);

      // 60 ticks: seconds every tick, one minute carry on the 60th
      for (int i = 0; i < 60; i++)
         press(M_TICK, 1'b1, (i == 59) ? V_SM_UP : V_S_UP);
      drain("sixty_ticks");

      // sec=0, min=1 -> edit both to 59, then one tick carries into hours
      press(M_EDIT, 1'b0, 5'b00000);
      chk_st("enter_edit", 4'b0010);
      press(M_RIGHT, 1'b0, 5'b00000);
      press(M_DOWN, 1'b1, V_M_DN);
      press(M_DOWN, 1'b1, V_M_DN);
      press(M_RIGHT, 1'b0, 5'b00000);
      chk_st("edit_s_sel", 4'b1010);
      press(M_DOWN, 1'b1, V_S_DN);
      press(M_EDIT, 1'b0, 5'b00000);
      chk_st("exit_edit", 4'b1100);
      press(M_TICK, 1'b1, V_HMS_UP);
      drain("full_carry");

      // edit, right, down: minute down pulse
      press(M_EDIT, 1'b0, 5'b00000);
      press(M_RIGHT, 1'b0, 5'b00000);
      press(M_DOWN, 1'b1, V_M_DN);
      chk_st("edit_m_sel", 4'b0110);
      press(M_EDIT, 1'b0, 5'b00000);
      drain("minute_down");

      // edit edge with coincident tick: tick dropped, blink 0
      press(M_EDIT | M_TICK, 1'b0, 5'b00000);
      chk_st("edit_with_tick", 4'b0010);
      press(M_TICK, 1'b0, 5'b00000);
      chk_st("blink_toggle", 4'b0011);
      press(M_UP | M_DOWN, 1'b0, 5'b00000);
      press(M_UP, 1'b1, V_H_UP);
      chk_st("hour_up_keeps_blink", 4'b0011);
      press(M_LEFT, 1'b0, 5'b00000);
      chk_st("left_wraps_to_s", 4'b1010);
      press(M_RIGHT, 1'b0, 5'b00000);
      chk_st("right_wraps_to_h", 4'b0010);
      press(M_LEFT | M_RIGHT, 1'b0, 5'b00000);
      chk_st("left_right_ignored", 4'b0010);
      press(M_EDIT, 1'b0, 5'b00000);
      chk_st("back_to_run", 4'b1100);
      press(M_LEFT, 1'b0, 5'b00000);
      press(M_DOWN, 1'b0, 5'b00000);
      chk_st("run_ignores_buttons", 4'b1100);
      drain("edit_mix");

      // reset mid-edit with buttons held through release
      press(M_EDIT, 1'b0, 5'b00000);
      press(M_LEFT, 1'b0, 5'b00000);
      press(M_DOWN, 1'b1, V_S_DN);
      drain("pre_reset");
      @(negedge clk);
      rst = 1'b0;
      btn_up = 1'b1;
      btn_edit = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_st("held_through_reset", 4'b1100);
      btn_up = 1'b0;
      btn_edit = 1'b0;
      @(negedge clk);
      press(M_TICK, 1'b1, V_S_UP);
      drain("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
